sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter: DATA_WIDTH, 16, data bus width in bits (1..64) SHALL be supported.
REQ-002 Parameter: DEPTH, 8, entry count; power of two, minimum 2.
REQ-003 Parameter: AF_MARGIN, 1, almost_full asserts when count >= DEPTH-AF_MARGIN; legal 1..DEPTH-1.
REQ-004 Parameter: AE_MARGIN, 1, almost_empty asserts when count <= AE_MARGIN; legal 1..DEPTH-1.
REQ-005 Ports SHALL be:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  read data.
- wr_ack  out  1  previous-cycle write accepted.
- overflow  out  1  previous-cycle write rejected.
- underflow  out  1  previous-cycle read rejected.
- full, empty, almost_full, almost_empty  out  1 each  occupancy flags.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-006 Write accepted iff wr_en and (count < DEPTH); data_in stored at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-007 Read accepted iff rd_en and (count > 0); rd_ptr increments modulo DEPTH.
REQ-008 Simultaneous accepted read and write SHALL leave count unchanged.
REQ-009 Full with wr_en and rd_en both high: read accepted, write rejected, overflow=1 next cycle, count drops to DEPTH-1.
REQ-010 Empty with wr_en and rd_en both high: write accepted, read rejected, underflow=1 next cycle, count becomes 1.
REQ-011 wr_ack, overflow and underflow SHALL be registered; each reflects only the request of the immediately preceding cycle and holds for exactly one cycle per event.
REQ-012 full = (count==DEPTH); empty = (count==0); almost_full and almost_empty per REQ-003/004; all four combinational from registered count, with no extra latency.
REQ-013 Standard mode: data_out SHALL be registered, updated one cycle after an accepted read, and SHALL hold its value otherwise, including on rejected reads.
REQ-014 Pointers SHALL be $clog2(DEPTH) bits with natural wrap; count SHALL be held separately, with no full/empty pointer ambiguity.

Reset
REQ-015 rst high at a rising edge SHALL clear wr_ptr, rd_ptr, count, data_out, wr_ack, overflow and underflow to 0. After reset: empty=1, almost_empty=1, full=0, almost_full=0.
REQ-016 Reset mid-operation SHALL discard all stored entries. Requests in the reset cycle SHALL be ignored and no flag SHALL be raised. Memory contents are not cleared.

Configuration
REQ-017 Macro FIFO_FWFT_EN defined: first-word-fall-through mode.
- data_out SHALL continuously present mem[rd_ptr].
- An accepted read pops that word; the next word appears in the same cycle the pointer advances.
- data_out is don't-care while empty.
REQ-018 Macro FIFO_FWFT_EN undefined: standard registered-read behaviour per REQ-013. All other requirements are identical in both modes.

Structure
REQ-019 Package fifo_cfg_pkg SHALL hold the default DATA_WIDTH, DEPTH and margin constants and a typedef fifo_status_t (packed: full, empty, almost_full, almost_empty, overflow, underflow, wr_ack) for use by benches. shared_pkg SHALL remain bench-only.
REQ-020 Storage SHALL be a sub-module fifo_mem: DEPTH x DATA_WIDTH, one synchronous write port, one asynchronous read port. Pointer, count and flag logic SHALL live in sync_fifo_param.

Verification (DEPTH=8, DATA_WIDTH=16, margins=1, standard mode unless stated)
REQ-021 Reset, then 8 writes 16'h0001..16'h0008 -> wr_ack=1 each following cycle, count=8, full=1, almost_full=1 from count=7.
REQ-022 Full FIFO, wr_en=1 with data 16'hDEAD -> overflow=1 next cycle, count stays 8, 16'hDEAD never read back.
REQ-023 Full FIFO, wr_en=rd_en=1 -> data_out=16'h0001 next cycle, overflow=1, count=7.
REQ-024 Empty FIFO, rd_en=1 -> underflow=1 next cycle, data_out unchanged. wr_en=rd_en=1 with 16'h00AA -> underflow=1, count=1.
REQ-025 12 interleaved write/read pairs (pointer wrap past 8) -> read data order equals write order, count never exceeds 8.
REQ-026 With FIFO_FWFT_EN: write 16'h1234 into empty FIFO -> data_out=16'h1234 in the cycle after the write with no rd_en. rst asserted with count=5 -> count=0 and empty=1 after one edge.

Source files
------------

// File: rtl/fifo_cfg_pkg.sv
// Shared configuration for the synchronous FIFO: default sizing constants
// and a packed status word that benches use to bundle the occupancy and
// event flags.
// Optional feature macro: FIFO_FWFT_EN (first-word-fall-through read port).
package fifo_cfg_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_AF_MARGIN  = 1;
    localparam int DEF_AE_MARGIN  = 1;

    // Bundled view of every 1-bit FIFO output, MSB first.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
        logic wr_ack;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Storage array for sync_fifo_param: DEPTH x DATA_WIDTH, one synchronous
// write port and one asynchronous (combinational) read port.
// Contents are never reset; the owner tracks which entries are valid.
module fifo_mem
    import fifo_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: store one word per accepted write on the rising edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with occupancy flags and registered
// per-request event flags (wr_ack / overflow / underflow).
// Optional feature macro: FIFO_FWFT_EN. When defined, data_out shows the
// head entry continuously (first-word-fall-through); otherwise data_out is
// a register loaded one cycle after each accepted read.
//
// Request/accept semantics: wr_en and rd_en are requests sampled on every
// rising edge. A write is accepted when wr_en=1 and count < DEPTH; a read is
// accepted when rd_en=1 and count > 0; both decisions use the count held at
// that edge, so a full FIFO accepts the read but refuses the write, and an
// empty FIFO accepts the write but refuses the read. A refused request is
// dropped (not retried) and reported by overflow/underflow on the next cycle.
// Requests presented while rst is high are ignored entirely.
module sync_fifo_param
    import fifo_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_MARGIN  = DEF_AF_MARGIN,
    parameter int AE_MARGIN  = DEF_AE_MARGIN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [DATA_WIDTH-1:0]  data_in,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   wr_ack,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_LEVEL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL    = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_LEVEL    = CW'(AE_MARGIN);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // Occupancy flags come straight from the registered count, so they
    // change in the same cycle as count with no extra latency.
    assign full         = (count_q == DEPTH_LEVEL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_LEVEL);
    assign almost_empty = (count_q <= AE_LEVEL);
    assign count        = count_q;

    // Reset masks both requests so nothing is stored or popped that cycle.
    assign wr_accept = wr_en && !full  && !rst;
    assign rd_accept = rd_en && !empty && !rst;

    // Pointers wrap naturally; count is kept separately so full and empty
    // are never ambiguous when the pointers are equal.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_accept, rd_accept})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Event flags describe only the previous cycle's requests, so each one
    // is a single-cycle pulse per event.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_accept;
            overflow  <= wr_en && !wr_accept;
            underflow <= rd_en && !rd_accept;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd_data)
    );

`ifdef FIFO_FWFT_EN
    // Head entry is always visible; it is meaningless while empty.
    assign data_out = mem_rd_data;
`else
    logic [DATA_WIDTH-1:0] data_q;

    // Registered read: load the head word on an accepted read, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (rd_accept) begin
            data_q <= mem_rd_data;
        end
    end

    assign data_out = data_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DEPTH=8, DATA_WIDTH=16, margins=1).
// A reference occupancy count and an expected-data queue are advanced from
// the stimulus; every cycle the DUT flags, count and read data are compared
// against them with immediate assertions.
module tb_sync_fifo_param;
    import fifo_cfg_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          wr_ack, overflow, underflow;
    logic          full, empty, almost_full, almost_empty;
    logic [CW-1:0] count;

    int            pass_cnt  = 0;
    int            total_cnt = 0;
    int            m_count   = 0;
    logic [DW-1:0] last_data = '0;
    logic [DW-1:0] exp_q[$];

    sync_fifo_param #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_MARGIN  (1),
        .AE_MARGIN  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .data_in      (data_in),
        .data_out     (data_out),
        .wr_ack       (wr_ack),
        .overflow     (overflow),
        .underflow    (underflow),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
    );

    // Clock block
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Driver: present one cycle of requests, advance the reference model,
    // then compare everything the DUT shows after the edge.
    task automatic step(input string tag, input logic w, input logic r,
                        input logic [DW-1:0] d, input logic do_rst);
        logic         w_ok, r_ok;
        fifo_status_t exp_st, obs_st;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        rst     = do_rst;
        w_ok = !do_rst && w && (m_count < DEPTH);
        r_ok = !do_rst && r && (m_count > 0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b0;
        if (do_rst) begin
            exp_q.delete();
            m_count   = 0;
            last_data = '0;
        end else begin
            if (r_ok) begin
                last_data = exp_q.pop_front();
                m_count--;
            end
            if (w_ok) begin
                exp_q.push_back(d);
                m_count++;
            end
        end
        exp_st.full         = (m_count == DEPTH);
        exp_st.empty        = (m_count == 0);
        exp_st.almost_full  = (m_count >= DEPTH - 1);
        exp_st.almost_empty = (m_count <= 1);
        exp_st.overflow     = !do_rst && w && !w_ok;
        exp_st.underflow    = !do_rst && r && !r_ok;
        exp_st.wr_ack       = w_ok;
        obs_st = '{full, empty, almost_full, almost_empty, overflow, underflow, wr_ack};
        check({tag, ".status"}, 32'(obs_st), 32'(exp_st));
        check({tag, ".count"}, 32'(count), 32'(m_count));
`ifdef FIFO_FWFT_EN
        if (m_count > 0) check({tag, ".head"}, 32'(data_out), 32'(exp_q[0]));
`else
        check({tag, ".data_out"}, 32'(data_out), 32'(last_data));
`endif
    endtask

    initial begin
        // Reset block: two cycles of reset, then check the cleared state.
        step("rst0", 1'b0, 1'b0, '0, 1'b1);
        step("rst1", 1'b1, 1'b1, 16'h5555, 1'b1);

        // Fill to full with 0001..0008; almost_full must rise at count 7.
        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 1'b0, DW'(i), 1'b0);

        // Write while full: rejected, DEAD must never appear downstream.
        step("ovf", 1'b1, 1'b0, 16'hDEAD, 1'b0);

        // Full with both requests: read 0001 wins, write refused.
        step("full_rw", 1'b1, 1'b1, 16'hBEEF, 1'b0);

        // Drain the remaining seven entries 0002..0008.
        for (int i = 0; i < DEPTH - 1; i++) step("drain", 1'b0, 1'b1, '0, 1'b0);

        // Read while empty: underflow, data_out holds 0008.
        step("udf", 1'b0, 1'b1, '0, 1'b0);

        // Empty with both requests: write taken, read refused.
        step("empty_rw", 1'b1, 1'b1, 16'h00AA, 1'b0);
        step("rd_aa", 1'b0, 1'b1, '0, 1'b0);

        // Interleaved traffic that wraps both pointers past DEPTH.
        for (int i = 0; i < 3; i++) step("pre", 1'b1, 1'b0, DW'($urandom_range(0, 16'hFFFF)), 1'b0);
        for (int i = 0; i < 12; i++) step("pair", 1'b1, 1'b1, DW'($urandom_range(0, 16'hFFFF)), 1'b0);
        for (int i = 0; i < 12; i++) begin
            step("pw", 1'b1, 1'b0, DW'($urandom_range(0, 16'hFFFF)), 1'b0);
            step("pr", 1'b0, 1'b1, '0, 1'b0);
        end

        // Random mix including refused requests at both boundaries.
        for (int i = 0; i < 60; i++) begin
            step("mix", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 DW'($urandom_range(0, 16'hFFFF)), 1'b0);
        end

        // Reset mid-operation with five entries and live requests.
        while (m_count > 0) step("clr", 1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 5; i++) step("load5", 1'b1, 1'b0, DW'(16'h1230 + i), 1'b0);
        step("mid_rst", 1'b1, 1'b1, 16'h7777, 1'b1);
        step("post_udf", 1'b0, 1'b1, '0, 1'b0);
        step("post_wr", 1'b1, 1'b0, 16'h1234, 1'b0);
        step("post_rd", 1'b0, 1'b1, '0, 1'b0);

        // Final report
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
